// File: rtl/prog_loader.sv
// Framed byte-stream loader that assembles big-endian words into instruction memory.
// Optional trailing checksum byte and error state: define LOADER_CKSUM_EN.
module prog_loader #(
  parameter int         WIDTH    = 32,
  parameter int         ADDRSIZE = 12,
  parameter logic [7:0] SYNC     = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_hold
);

  typedef enum logic [3:0] {
    IDLE, AH, AL, CH, CL, DATA, WR, CKSUM, ERR
  } state_t;

  state_t state, nxt;

  logic [7:0]          ahi;
  logic [15:0]         cnt;
  logic [ADDRSIZE-1:0] ptr;
  logic [WIDTH-1:0]    word;
  logic [1:0]          bidx;
  logic                done_q;
  logic                hold_q;

  logic        xfer;
  logic        is_sync;
  logic        cnt_zero;
  logic        last_wr;
  logic [15:0] a16;

  assign xfer     = in_valid & in_ready;
  assign is_sync  = (in_data == SYNC);
  assign cnt_zero = ({cnt[15:8], in_data} == 16'd0);
  assign last_wr  = (cnt == 16'd1);
  assign a16      = {ahi, in_data};

`ifdef LOADER_CKSUM_EN
  localparam state_t END_ST = CKSUM;
  logic [7:0] cksum;
  logic       err_q;
  logic       ck_ok;

  assign ck_ok = (in_data == cksum);

  // Running XOR of every header and data byte after SYNC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum <= 8'h00;
      err_q <= 1'b0;
    end else if (xfer) begin
      if ((state == IDLE || state == ERR) && is_sync) begin
        cksum <= 8'h00;
        err_q <= 1'b0;
      end else if (state inside {AH, AL, CH, CL, DATA}) begin
        cksum <= cksum ^ in_data;
      end else if (state == CKSUM && !ck_ok) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  localparam state_t END_ST = IDLE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, ERR: if (xfer && is_sync) nxt = AH;
      AH:        if (xfer) nxt = AL;
      AL:        if (xfer) nxt = CH;
      CH:        if (xfer) nxt = CL;
      CL:        if (xfer) nxt = cnt_zero ? END_ST : DATA;
      DATA:      if (xfer && bidx == 2'd3) nxt = WR;
      WR:        nxt = last_wr ? END_ST : DATA;
`ifdef LOADER_CKSUM_EN
      CKSUM:     if (xfer) nxt = ck_ok ? IDLE : ERR;
`endif
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != WR);
    mem_we    = (state == WR);
    busy      = (state != IDLE) && (state != ERR);
    mem_addr  = ptr;
    mem_wdata = word;
    done      = done_q;
    cpu_hold  = hold_q;
`ifdef LOADER_CKSUM_EN
    err       = err_q;
`else
    err       = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ahi    <= 8'h00;
      cnt    <= 16'h0000;
      ptr    <= '0;
      word   <= '0;
      bidx   <= 2'd0;
      done_q <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (state == WR) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 16'd1;
`ifndef LOADER_CKSUM_EN
        if (last_wr) begin
          done_q <= 1'b1;
          hold_q <= 1'b0;
        end
`endif
      end else if (xfer) begin
        unique case (state)
          IDLE, ERR: if (is_sync) hold_q <= 1'b1;
          AH:        ahi <= in_data;
          AL:        ptr <= a16[ADDRSIZE-1:0];
          CH:        cnt[15:8] <= in_data;
          CL: begin
            cnt[7:0] <= in_data;
`ifndef LOADER_CKSUM_EN
            if (cnt_zero) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end
`endif
          end
          DATA: begin
            word <= {word[WIDTH-9:0], in_data};
            bidx <= bidx + 2'd1;
          end
`ifdef LOADER_CKSUM_EN
          CKSUM: if (ck_ok) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus,
// popped by a negedge monitor whenever mem_we is seen.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int fails = 0;
  int done_cnt = 0;
  int rdy_low = 0;
  logic [43:0] exp_q[$];
  logic [31:0] fw[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_vs_we", {63'd0, in_ready}, {63'd0, !mem_we});
      if (!in_ready) rdy_low++;
      if (done) done_cnt++;
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          vecs++;
          fails++;
          $display("FAIL unexpected_write: got %0h@%0h expected none",
                   mem_wdata, mem_addr);
        end else begin
          logic [43:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {52'd0, mem_addr}, {52'd0, e[43:32]});
          chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vecs++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic frame(input logic [15:0] a, input int n, input bit sync,
                       input bit badck, input int maxgap);
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [15:0] cn;
    logic [11:0] ea;
    ck = 8'h00;
    cn = n[15:0];
    if (sync) send(8'hA5, $urandom_range(0, maxgap));
    for (int i = 0; i < n; i++) begin
      ea = a[11:0] + i[11:0];
      exp_q.push_back({ea, fw[i]});
    end
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? a[15:8] : (k == 1) ? a[7:0] :
          (k == 2) ? cn[15:8] : cn[7:0];
      ck = ck ^ b;
      send(b, $urandom_range(0, maxgap));
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = fw[i][8*j +: 8];
        ck = ck ^ b;
        send(b, $urandom_range(0, maxgap));
      end
    end
`ifdef LOADER_CKSUM_EN
    send(ck ^ {7'd0, badck}, $urandom_range(0, maxgap));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_mem_addr"}, {52'd0, mem_addr}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
  endtask

  task automatic settle_check(input string tag, input int d0, input int dexp,
                              input logic hold);
    repeat (4) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(dexp));
    chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, hold});
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0;
    int r0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word frame at 0x010
    fw[0] = 32'h12345678;
    fw[1] = 32'h9ABCDEF0;
    d0 = done_cnt;
    r0 = rdy_low;
    frame(16'h0010, 2, 1'b1, 1'b0, 0);
    settle_check("c1", d0, 1, 1'b0);
    chk("c1_ready_low", 64'(rdy_low - r0), 64'd2);
    chk("c1_err", {63'd0, err}, 64'd0);

`ifdef LOADER_CKSUM_EN
    // Corrupted checksum: words land, then error
    d0 = done_cnt;
    frame(16'h0010, 2, 1'b1, 1'b1, 0);
    settle_check("c2", d0, 0, 1'b1);
    chk("c2_err", {63'd0, err}, 64'd1);
    chk("c2_busy", {63'd0, busy}, 64'd0);
`endif

    // Lone SYNC restarts a frame and re-holds the core
    send(8'hA5, 0);
    @(negedge clk);
    chk("sync_err", {63'd0, err}, 64'd0);
    chk("sync_busy", {63'd0, busy}, 64'd1);
    chk("sync_hold", {63'd0, cpu_hold}, 64'd1);

    // Wrap at 0xFFF, SYNC bytes inside the data
    fw[0] = 32'hA5A5A5A5;
    fw[1] = 32'h00C0FFEE;
    d0 = done_cnt;
    frame(16'h0FFF, 2, 1'b0, 1'b0, 1);
    settle_check("c3", d0, 1, 1'b0);

    // Upper address bits ignored
    fw[0] = 32'hDEADBEEF;
    d0 = done_cnt;
    frame(16'hA003, 1, 1'b1, 1'b0, 2);
    settle_check("hiaddr", d0, 1, 1'b0);

    // Empty frame: done right after the last byte
    d0 = done_cnt;
    frame(16'h0020, 0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("c4_done_imm", {63'd0, done}, 64'd1);
    settle_check("c4", d0, 1, 1'b0);

    // Reset after two data bytes
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h40, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("c5");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("c5_pending", 64'(exp_q.size()), 64'd0);

    // Junk before SYNC plus random gaps
    fw[0] = 32'h12345678;
    fw[1] = 32'h9ABCDEF0;
    d0 = done_cnt;
    r0 = rdy_low;
    send(8'h55, 2);
    send(8'h00, 1);
    frame(16'h0010, 2, 1'b1, 1'b0, 3);
    settle_check("c6", d0, 1, 1'b0);
    chk("c6_ready_low", 64'(rdy_low - r0), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
